ospfb_frame_buffer: RTL and testbench
=====================================

# ospfb_frame_buffer

Frame-aware output buffer on the OSPFB output. The OSPFB data stream cannot be back-pressured, so this block sits between the OSPFB output and the downstream consumer (capture VIP or packetizer).
- It checks every FFT frame for correct length and `tlast` placement.
- It stores only complete, good frames in a circular buffer and drops whole frames when space is short, so channel alignment is never lost.
- It replays stored frames on a back-pressured AXI-Stream master, tagging each beat with its frame sequence number.

## Interface
Parameters:
- `WIDTH`, default 16: bits per real/imag part; data is `2*WIDTH` as {im, re}.
- `FFT_LEN`, default 64: beats per frame; must be a power of two, at least 4.
- `DEPTH_FRAMES`, default 2: buffer capacity in frames; must be a power of two. Capacity `CAP = DEPTH_FRAMES*FFT_LEN`.
- `CNT_WID`, default 16: width of the frame sequence number and the drop counter.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rstn`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  2*WIDTH: OSPFB output sample.
- `s_axis_tvalid`  in  1: input beat valid. There is no `s_axis_tready`; every valid beat is consumed.
- `s_axis_tlast`  in  1: end-of-frame marker from the FFT.
- `s_axis_tuser`  in  8: FFT bin index; used only with `OSPFB_FRAME_BUF_STRICT_TUSER_EN`.
- `m_axis_tdata`  out  2*WIDTH: buffered sample.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tlast`  out  1: high on bin `FFT_LEN-1` of each output frame.
- `m_axis_tuser`  out  $clog2(FFT_LEN): output bin index.
- `m_axis_seq`  out  CNT_WID: sequence number of the frame the current beat belongs to.
- `clr`  in  1: synchronous clear of the sticky flags and the drop counter.
- `frames_dropped`  out  CNT_WID: saturating count of frames dropped because the buffer lacked space.
- `err_tlast_missing`  out  1: sticky; set when bin `FFT_LEN-1` arrives without `tlast`.
- `err_tlast_unexpected`  out  1: sticky; set when `tlast` arrives on any bin other than `FFT_LEN-1`.

## Operation
State and pointers:
- Write FSM states: `IDLE`, `ACCEPT`, `DROP`.
- Write pointer `wp`, committed write pointer `cwp`, read pointer `rp`; each is `$clog2(CAP)+1` bits with wrap.
- Input bin counter `ib`.

Frame start (in `IDLE`, `s_axis_tvalid` high):
- Compute `free = CAP - (cwp - rp)` from registered values. A read in the same cycle does not count toward `free`.
- If `free >= FFT_LEN`: go to `ACCEPT` and write the beat.
- Otherwise: go to `DROP`.
- In both cases set `ib` to 1.

`ACCEPT`:
- Each valid beat is written to `mem[wp]` along with `seq_next`, then `wp` increments.
- Good end of frame is `tlast` on bin `FFT_LEN-1`. On it:
  - `cwp <= wp + 1`.
  - `seq_next` increments, wrapping at 2^CNT_WID.
  - Go to `IDLE`.

`DROP`:
- Beats are discarded and `ib` keeps counting.
- At the frame-ending beat (bin `FFT_LEN-1` or any `tlast`), `frames_dropped` increments (saturating at all-ones) and the FSM goes to `IDLE`.
- `seq_next` is not incremented. A drop is therefore not visible as a gap in `m_axis_seq`; it shows only in `frames_dropped`.

Framing errors, in any state:
- `tlast` with `ib != FFT_LEN-1` sets `err_tlast_unexpected`.
- Bin `FFT_LEN-1` without `tlast` sets `err_tlast_missing`.
- In both cases the frame ends at that beat. In `ACCEPT`, `wp <= cwp` (rollback), so no part of the bad frame is ever output. Go to `IDLE`.
- A frame that is both too small to fit and malformed is counted as a drop and also raises the error flag.

Read side:
- Only data in `[rp, cwp)` is readable.
- Uses a synchronous-read memory plus a 2-entry output skid stage, so it sustains one beat per cycle while `m_axis_tready` is high.
- `m_axis_tuser` comes from the read-side bin counter. `m_axis_tlast` is high exactly when that counter is `FFT_LEN-1`.

AXIS rules:
- Once `m_axis_tvalid` is asserted, it and all `m_axis_*` payload signals stay stable until `m_axis_tready` is high.
- Output frames are never interleaved or truncated.

`clr`:
- Clears `err_*` and `frames_dropped`.
- If an event occurs in the same cycle as `clr`, the event wins: the flag stays set, or the counter becomes 1.

Reset (`rstn` low, at any time):
- All pointers, `ib`, and `seq_next` go to 0; the FSM goes to `IDLE`.
- Partial and stored frames are lost.
- All outputs are 0, including `m_axis_tvalid = 0`.

## Timing
- Commit latency: the good `tlast` beat is sampled at edge T. If the buffer was otherwise empty, `m_axis_tvalid` is high after edge T+2, presenting bin 0.
- Throughput: one beat in and one beat out per cycle simultaneously. With `m_axis_tready` held high there are no bubbles between back-to-back committed frames.
- Error and drop outputs are registered: they update on the edge that samples the offending beat.

## Configuration
- `OSPFB_FRAME_BUF_STRICT_TUSER_EN` defined: every valid input beat also checks `s_axis_tuser == ib`, zero-extended. On a mismatch:
  - The frame ends and is rolled back exactly as for an unexpected `tlast`.
  - `err_tlast_unexpected` is set.
  - The FSM returns to `IDLE`, so the next beat starts a new frame.
- Undefined: `s_axis_tuser` is ignored and has no logic attached.

## Test plan
- Reset, then 3 good 64-beat frames with `m_axis_tready` = 1 → 192 output beats in order; `m_axis_seq` = 0, 1, 2; `tlast` at bins 63, 127, 191; `m_axis_tvalid` rises 2 cycles after the first frame's `tlast`.
- `m_axis_tready` = 0 while 3 frames are sent (`DEPTH_FRAMES` = 2) → frames 0 and 1 stored, `frames_dropped` = 1; after releasing `tready`, exactly 128 beats with seq 0, 1.
- `tlast` on bin 10, then one good frame → `err_tlast_unexpected` = 1; output is only the good frame, with seq 0.
- 64 beats without `tlast`, then a good frame → `err_tlast_missing` = 1; output is only the good frame. Pulse `clr` → both flags 0 and `frames_dropped` = 0.
- Deassert `rstn` mid-output at beat 30 of a stored frame → all outputs 0 immediately; after release, a new frame outputs with seq 0.
- With `OSPFB_FRAME_BUF_STRICT_TUSER_EN`: `s_axis_tuser` skips from 5 to 7 → frame discarded and `err_tlast_unexpected` = 1. Without the macro, the same stimulus yields a clean output frame.

Source files
------------

// File: rtl/ospfb_frame_buffer.sv
// ospfb_frame_buffer
// Frame-aware output buffer for the OSPFB output stream. Incoming frames are
// checked for length and tlast placement. Only complete, good frames are
// committed to a circular buffer. A frame that does not fit is dropped
// whole. Stored frames are replayed on a back-pressured AXI-Stream master.
// Optional build macro: OSPFB_FRAME_BUF_STRICT_TUSER_EN. When it is defined,
// each input beat's s_axis_tuser is also checked against the expected bin.
module ospfb_frame_buffer #(
  parameter int WIDTH        = 16,
  parameter int FFT_LEN      = 64,
  parameter int DEPTH_FRAMES = 2,
  parameter int CNT_WID      = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [2*WIDTH-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [7:0]                 s_axis_tuser,
  output logic [2*WIDTH-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(FFT_LEN)-1:0] m_axis_tuser,
  output logic [CNT_WID-1:0]         m_axis_seq,
  input  logic                       clr,
  output logic [CNT_WID-1:0]         frames_dropped,
  output logic                       err_tlast_missing,
  output logic                       err_tlast_unexpected
);

  localparam int CAP = DEPTH_FRAMES * FFT_LEN;
  localparam int AW  = $clog2(CAP);
  localparam int PW  = AW + 1;
  localparam int IBW = $clog2(FFT_LEN);
  localparam int DW  = 2 * WIDTH;
  localparam int EW  = CNT_WID + DW;
  localparam logic [IBW-1:0] LAST_BIN = IBW'(FFT_LEN - 1);
  localparam logic [PW-1:0]  CAP_P    = PW'(CAP);
  localparam logic [PW-1:0]  LEN_P    = PW'(FFT_LEN);

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} wr_state_t;

  wr_state_t          wr_state;
  logic [PW-1:0]      wp, cwp, rp;
  logic [IBW-1:0]     ib;
  logic [CNT_WID-1:0] seq_next;
  logic [EW-1:0]      mem [CAP];

  logic [IBW-1:0] cur_bin;
  logic           is_last_bin, tlast_unexp, tlast_miss, tuser_bad, unexp_evt;
  logic           frame_bad, good_end, frame_end, fits, mem_we, drop_evt;
  logic [PW-1:0]  free;

  // Read side: one in-flight RAM read plus a 2-entry output skid
  logic                rd_pending, rd_issue, pop;
  logic [EW-1:0]       rd_q;
  logic [IBW-1:0]      rd_bin_q;
  logic [1:0]          sk_cnt;
  logic [IBW+EW-1:0]   sk0, sk1, push_word;
  logic [2:0]          occ;

  // Classify the current input beat. In IDLE the beat is always bin 0.
  always_comb begin
    cur_bin     = (wr_state == IDLE) ? '0 : ib;
    is_last_bin = (cur_bin == LAST_BIN);
    tlast_unexp = s_axis_tvalid && s_axis_tlast && !is_last_bin;
    tlast_miss  = s_axis_tvalid && !s_axis_tlast && is_last_bin;
`ifdef OSPFB_FRAME_BUF_STRICT_TUSER_EN
    tuser_bad   = s_axis_tvalid && (s_axis_tuser != 8'(cur_bin));
`else
    tuser_bad   = 1'b0;
`endif
    unexp_evt   = tlast_unexp || tuser_bad;
    frame_bad   = unexp_evt || tlast_miss;
    good_end    = s_axis_tvalid && s_axis_tlast && is_last_bin && !tuser_bad;
    frame_end   = frame_bad || good_end;
    // Space is judged from registered pointers only; reads this cycle do not count
    free        = CAP_P - (cwp - rp);
    fits        = (free >= LEN_P);
    mem_we      = s_axis_tvalid && !frame_bad &&
                  ((wr_state == ACCEPT) || ((wr_state == IDLE) && fits));
    drop_evt    = s_axis_tvalid && frame_end &&
                  ((wr_state == DROP) || ((wr_state == IDLE) && !fits));
  end

`ifndef OSPFB_FRAME_BUF_STRICT_TUSER_EN
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;
`endif

  // Write FSM, pointer commit/rollback, sticky error flags and drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state             <= IDLE;
      wp                   <= '0;
      cwp                  <= '0;
      ib                   <= '0;
      seq_next             <= '0;
      frames_dropped       <= '0;
      err_tlast_missing    <= 1'b0;
      err_tlast_unexpected <= 1'b0;
    end else begin
      if (unexp_evt)      err_tlast_unexpected <= 1'b1;
      else if (clr)       err_tlast_unexpected <= 1'b0;
      if (tlast_miss)     err_tlast_missing    <= 1'b1;
      else if (clr)       err_tlast_missing    <= 1'b0;
      if (drop_evt)
        frames_dropped <= clr ? CNT_WID'(1) :
                          ((frames_dropped == '1) ? frames_dropped
                                                  : frames_dropped + CNT_WID'(1));
      else if (clr)
        frames_dropped <= '0;

      if (s_axis_tvalid) begin
        case (wr_state)
          IDLE: begin
            ib <= IBW'(1);
            if (frame_end) begin
              wp       <= cwp;
              wr_state <= IDLE;
            end else if (fits) begin
              wp       <= wp + PW'(1);
              wr_state <= ACCEPT;
            end else begin
              wr_state <= DROP;
            end
          end
          ACCEPT: begin
            if (frame_bad) begin
              wp       <= cwp;
              wr_state <= IDLE;
            end else if (good_end) begin
              wp       <= wp + PW'(1);
              cwp      <= wp + PW'(1);
              seq_next <= seq_next + CNT_WID'(1);
              wr_state <= IDLE;
            end else begin
              wp <= wp + PW'(1);
              ib <= ib + IBW'(1);
            end
          end
          DROP: begin
            if (frame_end) wr_state <= IDLE;
            else           ib       <= ib + IBW'(1);
          end
          default: wr_state <= IDLE;
        endcase
      end
    end
  end

  // Issue a read only when the skid is guaranteed room for the returning word
  always_comb begin
    pop       = (sk_cnt != 2'd0) && m_axis_tready;
    occ       = {1'b0, sk_cnt} + {2'b0, rd_pending} - {2'b0, pop};
    rd_issue  = (rp != cwp) && (occ < 3'd2);
    push_word = {rd_bin_q, rd_q};
  end

  // Frame storage: synchronous write, registered read
  always_ff @(posedge clk) begin
    if (mem_we)   mem[wp[AW-1:0]] <= {seq_next, s_axis_tdata};
    if (rd_issue) rd_q            <= mem[rp[AW-1:0]];
  end

  // Read pointer and output skid. Frames are FFT_LEN-aligned, so rp's low bits are the bin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp         <= '0;
      rd_pending <= 1'b0;
      rd_bin_q   <= '0;
      sk_cnt     <= 2'd0;
      sk0        <= '0;
      sk1        <= '0;
    end else begin
      rd_pending <= rd_issue;
      if (rd_issue) begin
        rp       <= rp + PW'(1);
        rd_bin_q <= rp[IBW-1:0];
      end
      if (rd_pending && pop) begin
        if (sk_cnt == 2'd1) begin
          sk0 <= push_word;
        end else begin
          sk0 <= sk1;
          sk1 <= push_word;
        end
      end else if (pop) begin
        sk0    <= sk1;
        sk_cnt <= sk_cnt - 2'd1;
      end else if (rd_pending) begin
        if (sk_cnt == 2'd0) sk0 <= push_word;
        else                sk1 <= push_word;
        sk_cnt <= sk_cnt + 2'd1;
      end
    end
  end

  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign {m_axis_tuser, m_axis_seq, m_axis_tdata} = sk0;
  assign m_axis_tlast  = (m_axis_tuser == LAST_BIN);

endmodule

// File: tb/tb_ospfb_frame_buffer.sv
// Self-checking bench for ospfb_frame_buffer (default parameters).
// Expected output beats are queued as frames are driven and are compared at the
// DUT output. Each scenario task also checks flags and timing.
module tb_ospfb_frame_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [5:0]  m_axis_tuser;
  logic [15:0] m_axis_seq;
  logic        clr;
  logic [15:0] frames_dropped;
  logic        err_tlast_missing;
  logic        err_tlast_unexpected;

  int checks   = 0;
  int failures = 0;
  int beats_out = 0;
  logic [54:0] sb [$];
  logic [15:0] exp_seq = '0;

  ospfb_frame_buffer dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_seq(m_axis_seq),
    .clr(clr), .frames_dropped(frames_dropped),
    .err_tlast_missing(err_tlast_missing),
    .err_tlast_unexpected(err_tlast_unexpected)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard compare on every handshake, plus stall stability
  initial begin
    logic        prev_stall;
    logic [54:0] stall_word, word, exp;
    prev_stall = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      word = {m_axis_tuser, m_axis_tlast, m_axis_seq, m_axis_tdata};
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!m_axis_tvalid || word !== stall_word) begin
            failures++;
            $display("FAIL stall_stable: got valid=%0b word=%h required valid=1 word=%h",
                     m_axis_tvalid, word, stall_word);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_out++;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL extra_beat: got word=%h required no beat", word);
          end else begin
            exp = sb.pop_front();
            if (word !== exp) begin
              failures++;
              $display("FAIL out_beat: got bin=%0d last=%0b seq=%0d data=%h required bin=%0d last=%0b seq=%0d data=%h",
                       word[54:49], word[48], word[47:32], word[31:0],
                       exp[54:49], exp[48], exp[47:32], exp[31:0]);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        stall_word = word;
      end
    end
  end

  task automatic apply_reset();
    rstn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    sb.delete();
    exp_seq = '0;
    #1 rstn = 1'b1;
  endtask

  // Drive nbeats continuous beats; tlast on beat tlast_bin (-1 for none)
  task automatic send_frame(input int nbeats, input int tlast_bin, input bit store,
                            input bit tuser_skip);
    logic [31:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = (b == tlast_bin);
      s_axis_tuser  = (tuser_skip && b >= 6) ? 8'(b + 1) : 8'(b);
      if (store) sb.push_back({6'(b), (b == 63), exp_seq, d});
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (store) exp_seq++;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats still pending required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
    clr = 1'b0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0 ||
        m_axis_tuser !== 6'd0 || m_axis_seq !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b data=%h last=%0b user=%0d seq=%0d required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_seq);
    end
    checks++;
    if (frames_dropped !== 16'd0 || err_tlast_missing !== 1'b0 || err_tlast_unexpected !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got dropped=%0d miss=%0b unexp=%0b required 0 0 0",
               frames_dropped, err_tlast_missing, err_tlast_unexpected);
    end
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_empty_valid: got %0b required 0", m_axis_tvalid);
    end
  endtask

  task automatic test_good_frames();
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(64, 63, 1'b1, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL latency_t0: got valid=%0b required 0", m_axis_tvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL latency_t1: got valid=%0b required 0", m_axis_tvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 6'd0 || m_axis_seq !== 16'd0) begin
      failures++;
      $display("FAIL latency_t2: got valid=%0b bin=%0d seq=%0d required 1 0 0",
               m_axis_tvalid, m_axis_tuser, m_axis_seq);
    end
    send_frame(64, 63, 1'b1, 1'b0);
    send_frame(64, 63, 1'b1, 1'b0);
    wait_drain("good_frames");
  endtask

  task automatic test_back_to_back();
    int run;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(64, 63, 1'b1, 1'b0);
    send_frame(64, 63, 1'b1, 1'b0);
    send_frame(64, 63, 1'b0, 1'b0);
    checks++;
    if (frames_dropped !== 16'd1) begin
      failures++;
      $display("FAIL overflow_dropped: got %0d required 1", frames_dropped);
    end
    checks++;
    if (err_tlast_missing !== 1'b0 || err_tlast_unexpected !== 1'b0) begin
      failures++;
      $display("FAIL overflow_errs: got miss=%0b unexp=%0b required 0 0",
               err_tlast_missing, err_tlast_unexpected);
    end
    repeat (5) @(posedge clk);
    #1 m_axis_tready = 1'b1;
    run = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) run++;
      else break;
    end
    checks++;
    if (run != 128) begin
      failures++;
      $display("FAIL no_bubble_run: got %0d consecutive valid cycles required 128", run);
    end
    wait_drain("overflow");
  endtask

  task automatic test_tlast_unexpected();
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(11, 10, 1'b0, 1'b0);
    checks++;
    if (err_tlast_unexpected !== 1'b1 || err_tlast_missing !== 1'b0) begin
      failures++;
      $display("FAIL unexp_flag: got unexp=%0b miss=%0b required 1 0",
               err_tlast_unexpected, err_tlast_missing);
    end
    send_frame(64, 63, 1'b1, 1'b0);
    wait_drain("unexpected");
  endtask

  task automatic test_tlast_missing_clr();
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(64, -1, 1'b0, 1'b0);
    checks++;
    if (err_tlast_missing !== 1'b1 || err_tlast_unexpected !== 1'b0) begin
      failures++;
      $display("FAIL miss_flag: got miss=%0b unexp=%0b required 1 0",
               err_tlast_missing, err_tlast_unexpected);
    end
    send_frame(64, 63, 1'b1, 1'b0);
    wait_drain("missing");
    send_frame(4, 3, 1'b0, 1'b0);
    checks++;
    if (err_tlast_unexpected !== 1'b1) begin
      failures++;
      $display("FAIL unexp_before_clr: got %0b required 1", err_tlast_unexpected);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (err_tlast_missing !== 1'b0 || err_tlast_unexpected !== 1'b0 || frames_dropped !== 16'd0) begin
      failures++;
      $display("FAIL clr_result: got miss=%0b unexp=%0b dropped=%0d required 0 0 0",
               err_tlast_missing, err_tlast_unexpected, frames_dropped);
    end
    // tlast on bin 0 in the same cycle as clr: the event must win
    clr = 1'b1;
    send_frame(1, 0, 1'b0, 1'b0);
    clr = 1'b0;
    checks++;
    if (err_tlast_unexpected !== 1'b1 || err_tlast_missing !== 1'b0) begin
      failures++;
      $display("FAIL clr_event_wins: got unexp=%0b miss=%0b required 1 0",
               err_tlast_unexpected, err_tlast_missing);
    end
    wait_drain("clr");
  endtask

  task automatic test_reset_mid_output();
    int base, n;
    apply_reset();
    m_axis_tready = 1'b1;
    base = beats_out;
    send_frame(64, 63, 1'b1, 1'b0);
    n = 0;
    while ((beats_out - base) < 30 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((beats_out - base) < 30) begin
      failures++;
      $display("FAIL midreset_wait: got %0d beats required 30", beats_out - base);
    end
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0 ||
        m_axis_tuser !== 6'd0 || m_axis_seq !== 16'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%0b data=%h last=%0b user=%0d seq=%0d required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_seq);
    end
    apply_reset();
    send_frame(64, 63, 1'b1, 1'b0);
    wait_drain("midreset");
  endtask

  task automatic test_tuser_skip();
    apply_reset();
    m_axis_tready = 1'b1;
`ifdef OSPFB_FRAME_BUF_STRICT_TUSER_EN
    send_frame(64, 63, 1'b0, 1'b1);
    checks++;
    if (err_tlast_unexpected !== 1'b1) begin
      failures++;
      $display("FAIL tuser_strict_flag: got %0b required 1", err_tlast_unexpected);
    end
`else
    send_frame(64, 63, 1'b1, 1'b1);
    checks++;
    if (err_tlast_unexpected !== 1'b0 || err_tlast_missing !== 1'b0) begin
      failures++;
      $display("FAIL tuser_ignored_flags: got unexp=%0b miss=%0b required 0 0",
               err_tlast_unexpected, err_tlast_missing);
    end
`endif
    wait_drain("tuser");
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_back_to_back();
    test_tlast_unexpected();
    test_tlast_missing_clr();
    test_reset_mid_output();
    test_tuser_skip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
